// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage. Owns the PC and the IF/ID pipeline register and
// talks to instruction memory over a single-outstanding req/resp port.
// Consumes the hazard unit's stall / flush_if_id / branch_taken decisions.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   stall                          hold PC and IF/ID
//   flush_if_id                    invalidate IF/ID (loads NOP)
//   branch_taken, branch_target    redirect fetch (target low 2 bits forced 0)
//   imem_req_valid/addr/ready      fetch request channel
//   imem_resp_valid/data           instruction return channel
//   pc_if_id, instr_if_id,
//   valid_if_id                    IF/ID register contents
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush_if_id,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [XLEN-1:0] pc_if_id,
  output logic [31:0]     instr_if_id,
  output logic            valid_if_id
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     buf_q, buf_d;

  logic [XLEN-1:0] pc_if_id_q, pc_if_id_d;
  logic [31:0]     instr_if_id_q, instr_if_id_d;
  logic            valid_if_id_q, valid_if_id_d;

  logic            req_hs;
  logic            deliver;
  logic [31:0]     deliver_data;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_inc;

  // Request is a pure function of state and pc. It is additionally masked
  // while reset is asserted so the port is quiet during reset.
  assign imem_req_valid = (state_q == S_REQ) && rst_n;
  assign imem_req_addr  = pc_q;

  assign req_hs = (state_q == S_REQ) && imem_req_ready;
  assign tgt    = {branch_target[XLEN-1:2], 2'b00};
  assign pc_inc = pc_q + XLEN'(4);  // wraps modulo 2^XLEN

  // ---------------------------------------------------------------------
  // Fetch FSM: next state, pc, drop flag, hold buffer, delivery strobe
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    buf_d        = buf_q;
    deliver      = 1'b0;
    deliver_data = imem_resp_data;

    unique case (state_q)
      S_REQ: begin
        if (branch_taken) begin
          pc_d = tgt;
          // An accepted request to the old address must have its
          // response thrown away; otherwise just re-aim the request.
          if (req_hs) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end else if (req_hs) begin
          state_d = S_WAIT;
          drop_d  = 1'b0;
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (branch_taken || drop_q) begin
            // Discard; pc already points at the redirect (or is updated now).
            if (branch_taken) pc_d = tgt;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (!stall) begin
            deliver = 1'b1;
            pc_d    = pc_inc;
            state_d = S_REQ;
          end else begin
            buf_d   = imem_resp_data;
            state_d = S_HOLD;
          end
        end else if (branch_taken) begin
          pc_d   = tgt;
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        deliver_data = buf_q;
        if (branch_taken) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (!stall) begin
          deliver = 1'b1;
          pc_d    = pc_inc;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
    end
  end

  // ---------------------------------------------------------------------
  // IF/ID register: flush > stall > delivery > bubble
  // ---------------------------------------------------------------------
  always_comb begin
    pc_if_id_d    = pc_if_id_q;
    instr_if_id_d = instr_if_id_q;
    valid_if_id_d = valid_if_id_q;
    if (flush_if_id) begin
      valid_if_id_d = 1'b0;
      instr_if_id_d = NOP;
    end else if (stall) begin
      // hold everything
    end else if (deliver) begin
      // Delivery happens before pc advances, so pc_q is the word's PC.
      pc_if_id_d    = pc_q;
      instr_if_id_d = deliver_data;
      valid_if_id_d = 1'b1;
    end else begin
      valid_if_id_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if_id_q    <= '0;
      instr_if_id_q <= NOP;
      valid_if_id_q <= 1'b0;
    end else begin
      pc_if_id_q    <= pc_if_id_d;
      instr_if_id_q <= instr_if_id_d;
      valid_if_id_q <= valid_if_id_d;
    end
  end

  assign pc_if_id    = pc_if_id_q;
  assign instr_if_id = instr_if_id_q;
  assign valid_if_id = valid_if_id_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that consumes the hazard unit's `stall`, `flush_if_id` and `branch_taken` outputs. It owns the PC and the IF/ID pipeline register, and drives a single-outstanding request/response port to instruction memory. It sits between instruction memory and the decode stage. Every stall and flush decision made by the hazard unit takes effect here at the clock edge.

## Interface
- `XLEN`, 32, address and PC width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0013, instruction (addi x0,x0,0) loaded into IF/ID on reset/flush

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  hold PC and IF/ID (load-use)
- `flush_if_id`  in  1  invalidate IF/ID this edge
- `branch_taken`  in  1  redirect fetch to `branch_target`
- `branch_target`  in  XLEN  redirect address (low 2 bits ignored, forced 0)
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  XLEN  fetch address
- `imem_req_ready`  in  1  memory accepts request
- `imem_resp_valid`  in  1  instruction returned (one per accepted request, ≥1 cycle after)
- `imem_resp_data`  in  32  instruction word
- `pc_if_id`  out  XLEN  PC of instruction in IF/ID
- `instr_if_id`  out  32  instruction in IF/ID
- `valid_if_id`  out  1  IF/ID holds a real instruction

## Operation
- Registers: `pc` (address of current/next fetch), `state`, `drop` flag, 32-bit hold buffer.
- States:
  - S_REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`; on valid&ready go to S_WAIT with `drop`=0.
  - S_WAIT: wait for `imem_resp_valid`.
  - S_HOLD: response captured in buffer, waiting for `stall` to drop.
- S_WAIT on response:
  - `drop`=1 → discard, go to S_REQ.
  - else `stall`=0 → deliver to IF/ID, `pc`←`pc`+4, go to S_REQ.
  - else → buffer the word, go to S_HOLD.
- S_HOLD: when `stall`=0, deliver buffered word with PC=`pc`, `pc`←`pc`+4, go to S_REQ.
- Redirect (`branch_taken`=1) has priority over everything, including `stall`. `pc`←`branch_target`. By state:
  - S_REQ with handshake this cycle: go to S_WAIT with `drop`=1.
  - S_REQ without handshake: stay in S_REQ. The address changes next cycle, which is allowed only because no handshake occurred.
  - S_WAIT: `drop`←1, stay, unless the response arrives the same cycle, in which case discard and go to S_REQ.
  - S_HOLD: discard buffer, go to S_REQ.
- IF/ID update priority, per edge:
  1. `flush_if_id`: `valid_if_id`←0, `instr_if_id`←`NOP`, `pc_if_id` holds.
  2. else `stall`: hold all.
  3. else delivery: load {pc, data, 1}.
  4. else `valid_if_id`←0, other fields hold.
- A `branch_taken` without `flush_if_id` discards only in-flight fetch data; IF/ID follows the priority list above.
- Address arithmetic is modulo 2^XLEN; `pc`+4 wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset (async assert, sync release): `pc`=`RESET_PC`, state=S_REQ, `drop`=0.
- Reset output values: `imem_req_valid`=0 while `rst_n`=0, `imem_req_addr`=`RESET_PC`, `pc_if_id`=0, `instr_if_id`=`NOP`, `valid_if_id`=0.
- First request is asserted in the first cycle after `rst_n` rises.
- Reset mid-transaction abandons the outstanding request. Memory is reset by the same `rst_n`, so no stale response is expected.
- Latency: request handshake in cycle N, response in cycle N+1 → `valid_if_id`=1 visible in cycle N+2.
- Peak throughput is 1 instruction per 2 cycles.
- `imem_req_valid`/`imem_req_addr` are combinational from state and `pc`; no input-to-output combinational paths.
- Never more than one request outstanding. `imem_req_valid`=0 in S_WAIT and S_HOLD.

## Test plan
- Reset then run, ready=1, 1-cycle memory returning addr^32'hA5A5_0000 → IF/ID shows pc 0,4,8 with matching data; `valid_if_id` alternates 1,0.
- Stall held 3 cycles while response arrives → state S_HOLD; IF/ID unchanged; after release the buffered word appears once with the correct PC and no duplicate fetch.
- `branch_taken`+`flush_if_id` with `branch_target`=32'h100 in S_WAIT → response dropped, `valid_if_id`=0 with `NOP`, next `imem_req_addr`=32'h100.
- `branch_taken` with `stall`=1 in S_HOLD → buffer discarded, next request to target, `stall` ignored for PC.
- `imem_req_ready` held low 5 cycles → `imem_req_valid` stays 1 with stable address; no IF/ID change beyond bubbles.
- `RESET_PC`=32'hFFFF_FFFC → second fetch address 32'h0; `rst_n` pulsed low while in S_WAIT → outputs return to reset values immediately.
